aes128_key_sched_ctrl: RTL and testbench

Iterative AES-128 key-schedule controller. It holds one instance of `expand_key_core` and steps it through all rounds, one round per clock. It stores the initial key and the NROUNDS derived round keys in an internal register file. A registered random-access read port serves those keys to the AES round datapath.

---
 rtl/aes128_key_sched_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_aes128_key_sched_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/aes128_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller: one expansion round per clock into a
// round-key register file with a registered read port. Optional KEY_SCHED_READ_GUARD_EN.
module expand_key_core (
    input  logic [127:0] key_in,
    input  logic [3:0]   rcon_index_in,
    output logic [127:0] key_out_c
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bit offset (255-x)*8 == {~x, 3'b000} because row 0 is the MSB end.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] pos;
        pos = {~x, 3'b000};
        return SBOX[pos +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    logic [31:0] w3_rot;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        w3_rot    = {key_in[23:0], key_in[31:24]};
        temp      = {sbox(w3_rot[31:24]), sbox(w3_rot[23:16]),
                     sbox(w3_rot[15:8]),  sbox(w3_rot[7:0])} ^ {rcon(rcon_index_in), 24'h000000};
        n0        = key_in[127:96] ^ temp;
        n1        = key_in[95:64]  ^ n0;
        n2        = key_in[63:32]  ^ n1;
        n3        = key_in[31:0]   ^ n2;
        key_out_c = {n0, n1, n2, n3};
    end
endmodule

module aes128_key_sched_ctrl #(
    parameter int unsigned NROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         rk_rd_valid
);
    localparam int unsigned KEY_W = 128;
    localparam int unsigned RND_W = 4;
    localparam int unsigned IDX_W = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   cur_q, cur_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               keys_valid_q, keys_valid_d;
    logic [KEY_W-1:0]   rk_q [NROUNDS+1];
    logic               rk_we_c;
    logic [RND_W-1:0]   rk_widx_c;
    logic [KEY_W-1:0]   rk_wdata_c;
    logic [KEY_W-1:0]   core_key_c;
    logic [KEY_W-1:0]   rd_sel_c;
    logic [KEY_W-1:0]   rd_data_q;
    logic               rd_valid_q;

    expand_key_core u_core (
        .key_in        (cur_q),
        .rcon_index_in (rnd_q),
        .key_out_c     (core_key_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cur_q        <= '0;
            rnd_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            rnd_q        <= rnd_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
        end
    end

    // Next-state logic; rnd parks at NROUNDS on the final round instead of wrapping.
    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rnd_d        = rnd_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        rk_we_c      = 1'b0;
        rk_widx_c    = rnd_q;
        rk_wdata_c   = core_key_c;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = EXPAND;
                    rk_we_c      = 1'b1;
                    rk_widx_c    = '0;
                    rk_wdata_c   = key_in;
                    cur_d        = key_in;
                    rnd_d        = RND_W'(1);
                    busy_d       = 1'b1;
                    keys_valid_d = 1'b0;
                end
            end
            EXPAND: begin
                rk_we_c = 1'b1;
                cur_d   = core_key_c;
                if (rnd_q == RND_W'(NROUNDS)) begin
                    state_d      = IDLE;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    keys_valid_d = 1'b1;
                end else begin
                    rnd_d = rnd_q + RND_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= int'(NROUNDS); i++) rk_q[i] <= '0;
        end else if (rk_we_c) begin
            for (int i = 0; i <= int'(NROUNDS); i++) begin
                if (rk_widx_c == RND_W'(i)) rk_q[i] <= rk_wdata_c;
            end
        end
    end

    // Read mux sees pre-edge contents, so a same-edge write returns the old key.
    always_comb begin
        rd_sel_c = '0;
        for (int i = 0; i <= int'(NROUNDS); i++) begin
            if (rk_rd_idx == IDX_W'(i)) rd_sel_c = rk_q[i];
        end
`ifdef KEY_SCHED_READ_GUARD_EN
        if (!keys_valid_q) rd_sel_c = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rk_rd_en;
            if (rk_rd_en) rd_data_q <= rd_sel_c;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign keys_valid  = keys_valid_q;
    assign rk_rd_data  = rd_data_q;
    assign rk_rd_valid = rd_valid_q;
endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Self-checking bench for aes128_key_sched_ctrl: FIPS-197 schedules, restart/reset
// corners and a read-data scoreboard.
module tb_aes128_key_sched_ctrl;
    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] RK4_A = 128'hef44a541a8525b7fb671253bdb0bad00;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key_in;
    logic         busy, done, keys_valid;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;

    int unsigned  checks = 0;
    int unsigned  errors = 0;
    logic [127:0] sb_q[$];
    vec_t         tbl[20];

    aes128_key_sched_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .key_in      (key_in),
        .busy        (busy),
        .done        (done),
        .keys_valid  (keys_valid),
        .rk_rd_en    (rk_rd_en),
        .rk_rd_idx   (rk_rd_idx),
        .rk_rd_data  (rk_rd_data),
        .rk_rd_valid (rk_rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] gexp(input logic [127:0] raw, input bit kv);
`ifdef KEY_SCHED_READ_GUARD_EN
        return kv ? raw : 128'h0;
`else
        return raw;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctrl(input int c, input logic d, input logic b, input logic k);
        chk($sformatf("done@%0d", c), 128'(done), 128'(d));
        chk($sformatf("busy@%0d", c), 128'(busy), 128'(b));
        chk($sformatf("keys_valid@%0d", c), 128'(keys_valid), 128'(k));
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            rk_rd_en  = 1'b1;
            rk_rd_idx = tbl[i].idx;
            sb_q.push_back(gexp(tbl[i].exp, 1'b1));
            step();
        end
        rk_rd_en = 1'b0;
        step();
    endtask

    // Scoreboard: valid must follow the sampled enable; data must match the oldest expectation.
    always begin
        logic en_s;
        @(posedge clk);
        en_s = rk_rd_en && reset;
        #1;
        chk("rd_valid", 128'(rk_rd_valid), 128'(en_s));
        if (rk_rd_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_data: valid with no pending read, got %h", rk_rd_data);
            end else begin
                chk("rd_data", rk_rd_data, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'd0,  KEY_A};
        tbl[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        tbl[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        tbl[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        tbl[4]  = '{4'd4,  RK4_A};
        tbl[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        tbl[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        tbl[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        tbl[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        tbl[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        tbl[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        tbl[11] = '{4'd11, 128'h0};
        tbl[12] = '{4'd12, 128'h0};
        tbl[13] = '{4'd13, 128'h0};
        tbl[14] = '{4'd14, 128'h0};
        tbl[15] = '{4'd15, 128'h0};
        tbl[16] = '{4'd0,  KEY_B};
        tbl[17] = '{4'd1,  128'hd6aa74fdd2af72fadaa678f1d6ab76fe};
        tbl[18] = '{4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        tbl[19] = '{4'd13, 128'h0};

        reset     = 1'b0;
        start     = 1'b0;
        key_in    = '0;
        rk_rd_en  = 1'b0;
        rk_rd_idx = '0;
        step();
        step();
        chk_ctrl(-1, 1'b0, 1'b0, 1'b0);
        chk("reset rd_valid", 128'(rk_rd_valid), 128'd0);
        chk("reset rd_data", rk_rd_data, 128'h0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // FIPS key, start re-pulsed at cycles 3 and 7, idx 4 read every cycle.
        start     = 1'b1;
        key_in    = KEY_A;
        rk_rd_en  = 1'b1;
        rk_rd_idx = 4'd4;
        sb_q.push_back(128'h0);
        for (int c = 0; c <= 11; c++) begin
            step();
            start  = (c == 2 || c == 6);
            key_in = start ? '1 : KEY_A;
            chk_ctrl(c, c == 10, c < 10, c >= 10);
            if (c < 11) sb_q.push_back(gexp((c + 1 >= 5) ? RK4_A : 128'h0, c + 1 >= 11));
            else rk_rd_en = 1'b0;
        end
        step();
        run_table(0, 15);

        // Reset in the middle of an expansion, then read back the cleared file.
        start  = 1'b1;
        key_in = KEY_B;
        for (int c = 0; c <= 4; c++) begin
            step();
            start = 1'b0;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_ctrl(99, 1'b0, 1'b0, 1'b0);
        chk("midreset rd_valid", 128'(rk_rd_valid), 128'd0);
        chk("midreset rd_data", rk_rd_data, 128'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        rk_rd_en  = 1'b1;
        rk_rd_idx = 4'd0;
        sb_q.push_back(128'h0);
        step();
        rk_rd_idx = 4'd4;
        sb_q.push_back(128'h0);
        step();
        rk_rd_en = 1'b0;
        step();

        // Fresh FIPS expansion, then KEY_B started in the done cycle.
        start  = 1'b1;
        key_in = KEY_A;
        for (int c = 0; c <= 21; c++) begin
            step();
            start    = (c == 10);
            key_in   = (c == 10) ? KEY_B : KEY_A;
            rk_rd_en = (c == 10 || c == 11);
            if (c == 10) begin
                rk_rd_idx = 4'd0;
                sb_q.push_back(gexp(KEY_A, 1'b1));
            end
            if (c == 11) begin
                rk_rd_idx = 4'd10;
                sb_q.push_back(gexp(tbl[10].exp, 1'b0));
            end
            chk_ctrl(c, c == 10 || c == 21, c < 10 || (c >= 11 && c < 21), c == 10 || c >= 21);
        end
        step();
        run_table(16, 19);

        chk("scoreboard empty", 128'(sb_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
